// File: rtl/adc_pkg.sv
// Shared definitions for the ramp/comparator conversion chain: default widths,
// sequencer state encoding and a helper to pull one pixel code out of a flat bus.
package adc_pkg;

  localparam int NUM_PIXELS_DEF = 5;
  localparam int CODE_W_DEF     = 8;
  localparam int CODE_W_MAX     = 16;
  localparam int FLAT_W_MAX     = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } rcg_state_t;

  // Extract pixel idx from a flat code bus, pixel i at bits [i*code_w +: code_w].
  function automatic logic [CODE_W_MAX-1:0] pixel_code(
    input logic [FLAT_W_MAX-1:0] flat,
    input int unsigned           idx,
    input int unsigned           code_w
  );
    logic [FLAT_W_MAX-1:0] shifted;
    logic [CODE_W_MAX-1:0] mask;
    shifted = flat >> (idx * code_w);
    mask    = (CODE_W_MAX'(1) << code_w) - CODE_W_MAX'(1);
    return shifted[CODE_W_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/ramp_counter.sv
// Saturating ramp counter: clears on clr, advances on en, sticks at full scale.
module ramp_counter #(
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [CODE_W-1:0] count,
  output logic              at_max
);

  assign at_max = (count == {CODE_W{1'b1}});

  // Ramp value register; clear has priority over advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + CODE_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ramp_comp_gen.sv
// Single-slope ramp sequencer with an emulated comparator bank: one monotone
// comp edge per pixel per sweep, then a short hold and a one-cycle done pulse.
module ramp_comp_gen
  import adc_pkg::*;
#(
  parameter int NUM_PIXELS  = NUM_PIXELS_DEF,
  parameter int CODE_W      = CODE_W_DEF,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_PIXELS*CODE_W-1:0] code_flat,
  output logic [NUM_PIXELS-1:0]        comp,
  output logic [CODE_W-1:0]            ramp_code,
  output logic                         busy,
  output logic                         done
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  rcg_state_t state, state_next;

  logic [NUM_PIXELS-1:0][CODE_W-1:0] code_q, code_next;
  logic [HOLD_W-1:0]                 hold_cnt, hold_cnt_next;
  logic [CODE_W-1:0]                 ramp_next;
  logic [NUM_PIXELS-1:0]             comp_next;
  logic                              cnt_clr, cnt_en, at_max, capture, active_next;

  ramp_counter #(.CODE_W(CODE_W)) u_ramp_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (ramp_code),
    .at_max (at_max)
  );

  // Sequencer next state, counter control and the ramp value the flops will hold next.
  always_comb begin
    state_next    = state;
    capture       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    ramp_next     = ramp_code;
    hold_cnt_next = hold_cnt;
    if (abort) begin
      state_next    = IDLE;
      cnt_clr       = 1'b1;
      ramp_next     = '0;
      hold_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_clr       = 1'b1;
          ramp_next     = '0;
          hold_cnt_next = '0;
          if (start) begin
            state_next = RAMP;
            capture    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        RAMP: begin
          if (at_max) begin
            state_next    = HOLD;
            hold_cnt_next = '0;
          end else begin
            cnt_en    = 1'b1;
            ramp_next = ramp_code + CODE_W'(1);
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = DONE;
            cnt_clr    = 1'b1;
            ramp_next  = '0;
          end else begin
            hold_cnt_next = hold_cnt + HOLD_W'(1);
          end
        end
        DONE: begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
          ramp_next  = '0;
        end
        default: begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
          ramp_next  = '0;
        end
      endcase
    end
  end

  // Compare against the next ramp value so comp comes straight from flops, aligned with ramp_code.
  always_comb begin
    code_next   = code_q;
    comp_next   = '0;
    active_next = (state_next == RAMP) || (state_next == HOLD);
    for (int i = 0; i < NUM_PIXELS; i++) begin
      code_next[i] = capture ? CODE_W'(pixel_code(FLAT_W_MAX'(code_flat), i, CODE_W))
                             : code_q[i];
      comp_next[i] = active_next ? (ramp_next >= code_next[i]) : 1'b0;
    end
  end

  // State, captured codes, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      code_q   <= '0;
      hold_cnt <= '0;
      comp     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      code_q   <= code_next;
      hold_cnt <= hold_cnt_next;
      comp     <= comp_next;
      busy     <= active_next;
      done     <= (state_next == DONE);
    end
  end

endmodule
